quick_rs232_rx_ovs: RTL
=======================

Name: quick_rs232_rx_ovs

Overview:
Next-generation RS-232 receiver for the QuickRS232 family. It samples the line at a configurable oversampling rate and decides each bit by majority vote. Frame format is selectable at runtime (5-9 data bits, five parity modes, 1/2 stop bits). Received frames and per-frame error flags go into a parametrised FIFO, with CTS-based hardware flow control; sits between the rx pin and user logic, alongside the existing transmitter.

Parameters:
CLK_FREQ, 50000000, system clock in Hz
BAUD_RATE, 115200, line bit rate
OVERSAMPLE, 16, samples per bit (>=8, even)
MAX_BYTE_LEN, 9, widest supported data field
FIFO_DEPTH, 16, receive FIFO entries (power of 2)
CTS_THRESHOLD, 12, fill level at or above which cts deasserts

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
rx  in  1  serial line (asynchronous, idle high)
cts  out  1  clear to send; 1 = host may transmit
cfg_byte_len  in  4  data bits, 5..9; other values treated as 8
cfg_parity  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; others = none
cfg_stop_bits  in  1  0 = one stop bit, 1 = two
rx_read  in  1  pop request; one pop per rising edge
rx_data  out  MAX_BYTE_LEN  FIFO head, right-justified, upper bits 0
rx_valid  out  1  FIFO not empty
rx_err  out  1  OR of head entry's parity/frame/break flags
err_parity  out  1  head entry parity error
err_frame  out  1  head entry framing error
err_break  out  1  head entry is a break
err_overrun  out  1  sticky: a frame was dropped on full FIFO
err_clear  in  1  clears err_overrun
rx_byte_received  out  1  one-clock pulse per completed frame
fifo_count  out  $clog2(FIFO_DEPTH)+1  current fill level

Behaviour:
- Reset values: cts=1, rx_valid=0, rx_data=0, all err_* =0, rx_err=0, rx_byte_received=0, fifo_count=0.
- Reset mid-frame: FSM to IDLE, FIFO emptied, partial frame discarded.
- rx passes a 2-FF synchroniser; all decisions use the synchronised value.
- Sample tick: divider = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated (27 for the defaults). The sample counter runs 0..OVERSAMPLE-1 per bit.
- Bit value: majority of samples OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
  - IDLE: on synced falling edge, latch cfg_* and go to START. Later cfg changes do not affect the frame in flight.
  - START: voted bit=1 -> false start, back to IDLE with no pulse; else go to DATA.
  - DATA: shift LSB-first, cfg_byte_len bits. Then PARITY if parity≠none, else STOP1.
  - PARITY: compare against expected bit (even: XOR of data; odd: inverted XOR; mark: 1; space: 0). Mismatch sets parity flag.
  - STOP1: voted 0 -> frame flag. Go to STOP2 if two stop bits, else complete.
  - STOP2: voted 0 -> frame flag; complete.
- Completion (at the stop-bit vote clock):
  - rx_byte_received pulses 1 clock.
  - Entry {break,frame,parity,data} is written to the FIFO; visible at head on the next clock if the FIFO was empty.
  - Break: data, parity bit and stop all 0. Sets break and frame flags and writes one entry, then BREAK_WAIT until the synced line is 1, then IDLE.
- FIFO is first-word-fall-through: rx_data and the flags always show the head. A pop advances the head on the next clock. A pop on empty is ignored.
- Full FIFO on write, no pop that clock: entry dropped, err_overrun=1, pulse still asserted. Write+pop in the same clock when full: both take effect, count unchanged, no overrun.
- err_overrun is sticky; err_clear clears it next clock. If err_clear and a new overrun occur together, the overrun wins.
- cts = (fifo_count < CTS_THRESHOLD), registered, one clock after the count changes.

Decomposition:
- Package quick_rs232_pkg: parity-mode constants, FSM state encodings, FIFO entry flag bit indices, divider computation function.
- Sub-module quick_rs232_fifo: synchronous FWFT FIFO with params WIDTH and DEPTH. Outputs count, full and empty; behaves as above on simultaneous write+read.

Test Plan:
- 8E1, 115200, 0x53 (parity bit 0) -> one rx_byte_received pulse; rx_data=0x053, all flags 0. 0x94 (parity 1) follows back-to-back -> second entry 0x094.
- 9N2, 0x1A5 -> rx_data=0x1A5, err_frame=0. Repeat with second stop bit driven 0 -> err_frame=1, rx_err=1.
- 8O1, 0x0F sent with parity bit 0 -> err_parity=1. Same byte with parity bit 1 -> err_parity=0.
- rx low for 4 clk only -> no pulse, fifo_count stays 0. rx held low for 3 frame times -> exactly one entry with err_break=1 and data 0; next frame after line returns high decodes correctly.
- 17 frames, no reads -> cts=0 from count 12; 17th frame dropped, err_overrun=1, fifo_count=16. Pop all entries in order -> cts=1 once below 12. err_clear -> err_overrun=0.
- rst pulsed mid-DATA of a frame -> no pulse, fifo_count=0, cts=1. The next full frame is received correctly.

Source files
------------

// File: rtl/quick_rs232_pkg.sv
// Shared types and helpers for the QuickRS232 oversampling receiver.
package quick_rs232_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK_WAIT
  } state_t;

  // Flag positions above the data field in a FIFO entry
  localparam int unsigned FLAG_PARITY = 0;
  localparam int unsigned FLAG_FRAME  = 1;
  localparam int unsigned FLAG_BREAK  = 2;
  localparam int unsigned NUM_FLAGS   = 3;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    int unsigned d;
    d = clk_freq / (baud * ovs);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic [3:0] decode_len(input logic [3:0] v);
    return (v >= 4'd5 && v <= 4'd9) ? v : 4'd8;
  endfunction

  function automatic parity_t decode_parity(input logic [2:0] v);
    case (v)
      3'd1:    return PAR_EVEN;
      3'd2:    return PAR_ODD;
      3'd3:    return PAR_MARK;
      3'd4:    return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/quick_rs232_fifo.sv
// Synchronous first-word-fall-through FIFO; head is zero while empty.
module quick_rs232_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_rd, do_wr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // A read on the same clock frees the slot, so a full FIFO still accepts the write
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/quick_rs232_rx_ovs.sv
// Oversampling RS-232 receiver with majority vote, runtime frame format,
// error-flagged receive FIFO and CTS flow control.
module quick_rs232_rx_ovs
  import quick_rs232_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned MAX_BYTE_LEN  = 9,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned CTS_THRESHOLD = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          cts,
  input  logic [3:0]                    cfg_byte_len,
  input  logic [2:0]                    cfg_parity,
  input  logic                          cfg_stop_bits,
  input  logic                          rx_read,
  output logic [MAX_BYTE_LEN-1:0]       rx_data,
  output logic                          rx_valid,
  output logic                          rx_err,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_break,
  output logic                          err_overrun,
  input  logic                          err_clear,
  output logic                          rx_byte_received,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int unsigned DIV     = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SAMP_W  = $clog2(OVERSAMPLE);
  localparam int unsigned MID     = OVERSAMPLE / 2;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = MAX_BYTE_LEN + NUM_FLAGS;

  state_t state, state_next;

  logic rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0]  div_cnt;
  logic [SAMP_W-1:0] samp_cnt;
  logic tick, vote_now, bit_end;
  logic s_a, s_b, bit_now;

  logic [3:0]              len_q, bit_idx;
  parity_t                 par_q;
  logic                    two_stop_q;
  logic [MAX_BYTE_LEN-1:0] data_q;
  logic                    par_bit_q, par_err_q, frm_err_q, exp_par;

  logic start_frame, shift_en, par_en, stop1_en, done, is_break;
  logic rx_read_d, pop, fifo_full, fifo_empty, overrun_set;
  logic [ENTRY_W-1:0] entry, head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Sample timing restarts from zero at the detected start edge
  assign tick     = (div_cnt == DIV_W'(DIV - 1));
  assign vote_now = tick && (samp_cnt == SAMP_W'(MID + 1));
  assign bit_end  = tick && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
  assign bit_now  = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);

  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= bit_end ? '0 : samp_cnt + SAMP_W'(1);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_a <= 1'b1;
      s_b <= 1'b1;
    end else if (tick) begin
      if (samp_cnt == SAMP_W'(MID - 1)) s_a <= rx_sync;
      if (samp_cnt == SAMP_W'(MID))     s_b <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop1_en    = 1'b0;
    done        = 1'b0;
    is_break    = 1'b0;
    case (state)
      ST_IDLE: if (rx_prev && !rx_sync) begin
        start_frame = 1'b1;
        state_next  = ST_START;
      end
      ST_START: begin
        if (vote_now && bit_now) state_next = ST_IDLE;
        else if (bit_end)        state_next = ST_DATA;
      end
      ST_DATA: begin
        shift_en = vote_now;
        if (bit_end && bit_idx == len_q - 4'd1)
          state_next = (par_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        par_en = vote_now;
        if (bit_end) state_next = ST_STOP1;
      end
      ST_STOP1: begin
        stop1_en = vote_now;
        if (vote_now && !bit_now && data_q == '0 && !par_bit_q) begin
          done       = 1'b1;
          is_break   = 1'b1;
          state_next = ST_BREAK_WAIT;
        end else if (vote_now && !two_stop_q) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else if (bit_end && two_stop_q) begin
          state_next = ST_STOP2;
        end
      end
      ST_STOP2: if (vote_now) begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_BREAK_WAIT: if (rx_sync) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    exp_par = 1'b0;
    case (par_q)
      PAR_EVEN: exp_par = ^data_q;
      PAR_ODD:  exp_par = ~^data_q;
      PAR_MARK: exp_par = 1'b1;
      default:  exp_par = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= 4'd8;
      par_q      <= PAR_NONE;
      two_stop_q <= 1'b0;
      data_q     <= '0;
      bit_idx    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      if (start_frame) begin
        len_q      <= decode_len(cfg_byte_len);
        par_q      <= decode_parity(cfg_parity);
        two_stop_q <= cfg_stop_bits;
        data_q     <= '0;
        bit_idx    <= '0;
        par_bit_q  <= 1'b0;
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
      end
      if (shift_en) data_q[bit_idx] <= bit_now;
      if (state == ST_DATA && bit_end) bit_idx <= bit_idx + 4'd1;
      if (par_en) begin
        par_bit_q <= bit_now;
        par_err_q <= (bit_now != exp_par);
      end
      if (stop1_en && !bit_now) frm_err_q <= 1'b1;
    end
  end

  // The stop vote of the completing clock is folded straight into the entry
  assign entry = {is_break, frm_err_q | ~bit_now | is_break, par_err_q & ~is_break, data_q};

  assign pop         = rx_read & ~rx_read_d;
  assign overrun_set = done & fifo_full & ~pop;

  quick_rs232_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (done),
    .wr_data (entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_data    = head[MAX_BYTE_LEN-1:0];
  assign err_parity = head[MAX_BYTE_LEN + FLAG_PARITY];
  assign err_frame  = head[MAX_BYTE_LEN + FLAG_FRAME];
  assign err_break  = head[MAX_BYTE_LEN + FLAG_BREAK];
  assign rx_err     = err_parity | err_frame | err_break;
  assign rx_valid   = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_read_d        <= 1'b0;
      rx_byte_received <= 1'b0;
      err_overrun      <= 1'b0;
      cts              <= 1'b1;
    end else begin
      rx_read_d        <= rx_read;
      rx_byte_received <= done;
      if (overrun_set)    err_overrun <= 1'b1;
      else if (err_clear) err_overrun <= 1'b0;
      cts <= (fifo_count < CNT_W'(CTS_THRESHOLD));
    end
  end

endmodule
